// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the register-file WRITE/READ port among NREQ requesters.
// One transaction in flight; read data is routed back to the winner after RD_LAT cycles.
module regfile_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 3,
    parameter int DW     = 2,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WE,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    RSP_VALID,
    output logic [DW-1:0]      RSP_DATA,
    output logic               WRITE,
    output logic               READ,
    output logic [AW-1:0]      ADDR,
    output logic [DW-1:0]      WRITE_DATA,
    input  logic [DW-1:0]      READ_DATA,
    output logic [1:0]         DBG_STATE
);

    // Handshake: a requester holds REQ (with WE/ADDR/WDATA stable) until its GNT
    // pulse; GNT means the access is on the port this cycle. RSP_VALID pulses once
    // per read, with RSP_DATA valid in that same cycle.

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;

    logic              found;
    logic [PW-1:0]     pick;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

    // First set REQ bit searching upward from rr_q, wrapping modulo NREQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                sel_we    = REQ_WE[i];
                sel_addr  = REQ_ADDR[i*AW +: AW];
                sel_wdata = REQ_WDATA[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    // Port outputs are loaded here so they are live during ISSUE.
                    win_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    write_d = sel_we;
                    read_d  = ~sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rr_d = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
                if (write_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CW'(RD_LAT-1);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = READ_DATA;
                    rsp_valid_d = NREQ'(1) << win_q;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            write_q     <= write_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign GNT        = gnt_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign WRITE      = write_q;
    assign READ       = read_q;
    assign ADDR       = addr_q;
    assign WRITE_DATA = wdata_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: one instance at RD_LAT=1 with a register-file
// model, a second at RD_LAT=3 for the aborted-read case.
module tb_regfile_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance at RD_LAT=1
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, rsp_valid;
  logic [DW-1:0]      rsp_data, wdata, rdata;
  logic               write, read;
  logic [AW-1:0]      addr;
  logic [1:0]         dbg;

  regfile_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .GNT(gnt), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .WRITE(write), .READ(read), .ADDR(addr), .WRITE_DATA(wdata),
    .READ_DATA(rdata), .DBG_STATE(dbg)
  );

  // instance at RD_LAT=3
  logic [NREQ-1:0]    req3, req3_we;
  logic [NREQ*AW-1:0] req3_addr;
  logic [NREQ*DW-1:0] req3_wdata;
  logic [NREQ-1:0]    gnt3, rsp_valid3;
  logic [DW-1:0]      rsp_data3, wdata3, rdata3;
  logic               write3, read3;
  logic [AW-1:0]      addr3;
  logic [1:0]         dbg3;

  regfile_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ(req3), .REQ_WE(req3_we), .REQ_ADDR(req3_addr),
    .REQ_WDATA(req3_wdata), .GNT(gnt3), .RSP_VALID(rsp_valid3), .RSP_DATA(rsp_data3),
    .WRITE(write3), .READ(read3), .ADDR(addr3), .WRITE_DATA(wdata3),
    .READ_DATA(rdata3), .DBG_STATE(dbg3)
  );

  // register-file models: 1-cycle memory, and a 3-stage pipe returning ADDR[1:0]
  logic [DW-1:0] mem [8];
  logic [DW-1:0] p0, p1, p2;
  initial begin
    foreach (mem[k]) mem[k] = '0;
    rdata = '0;
    p0 = '0; p1 = '0; p2 = '0;
  end
  always @(posedge clk) begin
    if (write) mem[addr] <= wdata;
    rdata <= read ? mem[addr] : '0;
    p0 <= read3 ? addr3[1:0] : '0;
    p1 <= p0;
    p2 <= p1;
  end
  assign rdata3 = p2;

  // scoreboard counters and checking task
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  logic [NREQ-1:0] rr_exp   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [AW-1:0]   rr_addr  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  int pulses;
  int lat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req3 = '0; req3_we = '0; req3_addr = '0; req3_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {gnt, rsp_valid, rsp_data, write, read, addr, wdata}, 0);
    check("rst_state", dbg, 0);
    rst = 1'b0;

    // single write from requester 2
    set_req(2, 1'b1, 3'd0, 2'b10);
    cyc();
    check("wr_gnt", gnt, 4'b0100);
    check("wr_strobes", {write, read}, 2'b10);
    check("wr_addr", addr, 3'd0);
    check("wr_wdata", wdata, 2'b10);
    check("wr_state", dbg, 1);
    req = '0;
    cyc();
    check("wr_after", {gnt, write, read}, 0);
    check("wr_idle", dbg, 0);
    check("wr_hold", {addr, wdata}, {3'd0, 2'b10});

    // single read from requester 1 (rr pointer is 3 here)
    set_req(1, 1'b0, 3'd0, 2'b00);
    cyc();
    check("rd_gnt", gnt, 4'b0010);
    check("rd_strobes", {write, read}, 2'b01);
    req = '0;
    cyc();
    check("rd_wait", {gnt, rsp_valid, write, read}, 0);
    check("rd_wait_state", dbg, 2);
    cyc();
    check("rd_rsp_valid", rsp_valid, 4'b0010);
    check("rd_rsp_data", rsp_data, 2'b10);
    cyc();
    check("rd_rsp_pulse", rsp_valid, 0);
    check("rd_rsp_hold", rsp_data, 2'b10);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst", {gnt, rsp_valid, rsp_data, write, read, addr, wdata}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // round-robin with all four requesting writes, held high
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'(i));
    cyc();
    check("rr_first", gnt, 4'b0001);
    check("rr_first_addr", addr, 3'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rr_gap", gnt, 0);
      cyc();
      check("rr_order", gnt, rr_exp[k]);
      check("rr_addr", addr, rr_addr[k]);
    end
    req = '0;
    cyc();

    // move rr pointer to 3, then requesters 0 and 1 compete
    set_req(2, 1'b1, 3'd5, 2'b01);
    cyc();
    check("wrap_pre", gnt, 4'b0100);
    req = '0;
    cyc();
    set_req(0, 1'b1, 3'd6, 2'b11);
    set_req(1, 1'b1, 3'd7, 2'b01);
    cyc();
    check("wrap_gnt0", gnt, 4'b0001);
    check("wrap_addr0", addr, 3'd6);
    req[0] = 1'b0;
    cyc();
    check("wrap_gap", gnt, 0);
    cyc();
    check("wrap_gnt1", gnt, 4'b0010);
    check("wrap_addr1", {addr, wdata}, {3'd7, 2'b01});
    req = '0;
    cyc();

    // read back address 7 through requester 3
    set_req(3, 1'b0, 3'd7, 2'b00);
    cyc();
    check("rd3_gnt", gnt, 4'b1000);
    req = '0;
    cyc();
    cyc();
    check("rd3_rsp_valid", rsp_valid, 4'b1000);
    check("rd3_rsp_data", rsp_data, 2'b01);

    // RD_LAT=3 read aborted by reset inside RDWAIT
    req3 = 4'b0001; req3_we = '0; req3_addr[2:0] = 3'd6;
    cyc();
    check("lat3_gnt", gnt3, 4'b0001);
    check("lat3_read", read3, 1'b1);
    req3 = '0;
    cyc();
    cyc();
    check("lat3_state", dbg3, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    pulses = (rsp_valid3 != 0) ? 1 : 0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      if (j == 1) rst = 1'b0;
      if (rsp_valid3 != 0) pulses++;
    end
    check("abort_no_rsp", pulses, 0);

    // next read on the RD_LAT=3 instance completes normally
    req3 = 4'b0100; req3_addr[8:6] = 3'd6;
    cyc();
    check("lat3_gnt2", gnt3, 4'b0100);
    req3 = '0;
    lat = 0;
    while (rsp_valid3 == 0 && lat < 10) begin
      cyc();
      lat++;
    end
    check("lat3_latency", lat, 4);
    check("lat3_rsp_valid", rsp_valid3, 4'b0100);
    check("lat3_rsp_data", rsp_data3, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single WRITE/READ/ADDR/WRITE_DATA/READ_DATA port of the small register-file block among NREQ independent requesters.
- Round-robin arbitration, one outstanding transaction at a time. Read data returns to the winning requester after a fixed port latency.
- Sits between requester logic (bus slaves, debug, init sequencer) and the register-file block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 3, address width
- DW, 2, data width
- RD_LAT, 1, cycles from READ assertion to valid READ_DATA at the port (>=1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  NREQ  per-requester request; held until matching GNT bit
- REQ_WE  in  NREQ  per-requester: 1=write, 0=read; held with REQ
- REQ_ADDR  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- REQ_WDATA  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- GNT  out  NREQ  one-hot, 1-cycle pulse: request accepted and issued
- RSP_VALID  out  NREQ  one-hot, 1-cycle pulse: read data valid for requester i
- RSP_DATA  out  DW  read data, valid when any RSP_VALID bit is set
- WRITE  out  1  register-file write strobe
- READ  out  1  register-file read strobe
- ADDR  out  AW  register-file address
- WRITE_DATA  out  DW  register-file write data
- READ_DATA  in  DW  register-file read data

Behaviour:
- Reset (async, RST=1):
  - Every output is 0: GNT, RSP_VALID, RSP_DATA, WRITE, READ, ADDR, WRITE_DATA.
  - State=IDLE, rr pointer=0, latency counter=0.
  - Reset mid-read discards the transaction; no RSP_VALID is produced afterwards.
- All outputs are registered; no combinational path from REQ to GNT, WRITE or READ.
- States: IDLE, ISSUE, RDWAIT.
- IDLE:
  - If REQ!=0, select the winner w = first set bit of REQ searching upward from rr pointer, wrapping modulo NREQ.
  - Latch w, REQ_WE[w], REQ_ADDR[w] and REQ_WDATA[w]; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - GNT[w]=1.
  - WRITE=latched WE, READ=~latched WE; ADDR and WRITE_DATA carry the latched values.
  - rr pointer <= (w+1) mod NREQ.
  - Write goes to IDLE. Read goes to RDWAIT and loads counter=RD_LAT-1.
- RDWAIT:
  - READ=WRITE=0.
  - If counter==0: RSP_DATA<=READ_DATA, RSP_VALID[w]=1 on the next cycle, go to IDLE.
  - Otherwise decrement the counter.
  - With RD_LAT=1, READ_DATA is sampled the cycle after READ.
- Outside ISSUE, WRITE and READ are 0; ADDR and WRITE_DATA hold their last value.
- RSP_DATA holds its value until the next read completes.
- Throughput: write = 2 cycles per transaction; read = RD_LAT+2 cycles from IDLE to the RSP_VALID cycle.
- Latency from REQ rising in IDLE to GNT = 2 cycles (arbitrate edge, then ISSUE cycle).
- Requester drops REQ before GNT (protocol violation): the latched transaction still issues.
- A requester must deassert REQ in the cycle after GNT unless it has a new transaction; REQ still high in IDLE is a new request.
- Simultaneous requests: lowest index at or above the rr pointer wins; the others wait. Every active requester is granted within NREQ transactions.
- REQ changes during ISSUE or RDWAIT are ignored until IDLE.
- WRITE and READ are never asserted together.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> all outputs 0 immediately; after release, first grant is to requester 0 when REQ=4'b1111.
- Single write: REQ[2]=1, WE=1, ADDR=3'd0, WDATA=2'b10 -> 2 cycles later GNT=4'b0100 with WRITE=1, ADDR=0, WRITE_DATA=2'b10; READ=0; IDLE next cycle.
- Single read: RD_LAT=1, REQ[1] read ADDR=0, register-file model returns 2'b10 -> READ=1 with GNT[1]; 2 cycles after ISSUE, RSP_VALID=4'b0010 and RSP_DATA=2'b10.
- Round-robin fairness: REQ=4'b1111 held, each requester re-requesting after its GNT -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Wrap and priority: rr pointer=3, REQ=4'b0011 -> grant 0 then 1; requester 3 absent does not stall arbitration.
- Reset during RDWAIT with RD_LAT=3 -> no RSP_VALID ever pulses for the aborted read; the next transaction completes normally.
